// File: rtl/hash_job_dispatcher.sv
// Job initiator for one hashing module: steps a nonce through begin_hash/hash_done
// handshakes until a valid hash, nonce exhaustion, host abort or watchdog timeout.
module hash_job_dispatcher #(
  parameter logic [31:0] NONCE_OFFSET = 32'd0,
  parameter logic [31:0] NONCE_STEP   = 32'd1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         job_start,
  input  logic         job_abort,
  input  logic [479:0] job_data,
  input  logic [255:0] job_difficulty,
  output logic         begin_hash,
  output logic         quit_hash,
  output logic [511:0] data_to_hash,
  output logic [255:0] difficulty,
  input  logic         hash_done,
  input  logic         valid_hash_flag,
  input  logic [255:0] valid_hash,
  output logic         job_busy,
  output logic         job_done,
  output logic         found,
  output logic         exhausted,
  output logic         timeout_err,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FINISH} state_t;

  // Watchdog counts completed WAIT cycles; expiry on the TIMEOUT-th one.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [479:0]   msg_q;
  logic [31:0]    nonce_q;
  logic [255:0]   diff_q;
  logic [7:0]     wdog_q;
  logic           flag_q;
  logic [255:0]   hash_q;
  logic           quit_q;
  logic           found_q, exh_q, tmo_q;
  logic [31:0]    fnonce_q;
  logic [255:0]   fhash_q;

  logic [32:0]    nonce_sum;
  logic           wd_expired;

  assign nonce_sum  = {1'b0, nonce_q} + {1'b0, NONCE_STEP};
  assign wd_expired = (wdog_q == WD_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Abort outranks hash_done and the watchdog in every active state.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (job_start) state_d = ISSUE;
      ISSUE:   state_d = job_abort ? FINISH : WAIT;
      WAIT: begin
        if (job_abort)       state_d = FINISH;
        else if (hash_done)  state_d = CHECK;
        else if (wd_expired) state_d = FINISH;
      end
      CHECK: begin
        if (job_abort || flag_q || nonce_sum[32]) state_d = FINISH;
        else                                      state_d = ISSUE;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    begin_hash = (state_q == ISSUE);
    job_busy   = (state_q != IDLE);
    job_done   = (state_q == FINISH);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      msg_q    <= '0;
      nonce_q  <= '0;
      diff_q   <= '0;
      wdog_q   <= '0;
      flag_q   <= 1'b0;
      hash_q   <= '0;
      quit_q   <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      tmo_q    <= 1'b0;
      fnonce_q <= '0;
      fhash_q  <= '0;
    end else begin
      quit_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (job_start) begin
            msg_q    <= job_data;
            diff_q   <= job_difficulty;
            nonce_q  <= NONCE_OFFSET;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            tmo_q    <= 1'b0;
            fnonce_q <= '0;
            fhash_q  <= '0;
          end
        end
        ISSUE: begin
          wdog_q <= '0;
          if (job_abort) quit_q <= 1'b1;
        end
        WAIT: begin
          if (job_abort) begin
            quit_q <= 1'b1;
          end else if (hash_done) begin
            flag_q <= valid_hash_flag;
            hash_q <= valid_hash;
          end else if (wd_expired) begin
            quit_q <= 1'b1;
            tmo_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        CHECK: begin
          if (job_abort) begin
            quit_q <= 1'b1;
          end else if (flag_q) begin
            fnonce_q <= nonce_q;
            fhash_q  <= hash_q;
            found_q  <= 1'b1;
          end else if (nonce_sum[32]) begin
            exh_q <= 1'b1;
          end else begin
            nonce_q <= nonce_sum[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign quit_hash    = quit_q;
  assign data_to_hash = {msg_q, nonce_q};
  assign difficulty   = diff_q;
  assign found        = found_q;
  assign exhausted    = exh_q;
  assign timeout_err  = tmo_q;
  assign found_nonce  = fnonce_q;
  assign found_hash   = fhash_q;

endmodule

// File: tb/tb_hash_job_dispatcher.sv
// Directed bench: three dispatchers with different nonce/timeout parameters, each
// paired with a simple latency model of a hashing module.
module tb_hash_job_dispatcher;

  localparam int N = 3;
  localparam logic [95:0] OFFS  = {32'hFFFF_FFFE, 32'd2, 32'd0};
  localparam logic [95:0] STEPS = {32'd1, 32'd4, 32'd1};
  localparam logic [2:0]  MODEL_LAT = 3'd3;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic         job_start [N];
  logic         job_abort [N];
  logic [479:0] job_data [N];
  logic [255:0] job_difficulty [N];
  wire          begin_hash [N];
  wire          quit_hash [N];
  wire  [511:0] data_to_hash [N];
  wire  [255:0] difficulty [N];
  wire          hash_done [N];
  wire          valid_hash_flag [N];
  wire  [255:0] valid_hash [N];
  wire          job_busy [N];
  wire          job_done [N];
  wire          found [N];
  wire          exhausted [N];
  wire          timeout_err [N];
  wire  [31:0]  found_nonce [N];
  wire  [255:0] found_hash [N];

  logic         mute [N];
  logic [31:0]  target [N];
  logic         man_done [N];
  logic         man_flag [N];
  logic [255:0] man_hash [N];
  logic [2:0]   mcnt [N];
  logic [31:0]  mnonce [N];
  logic         md_done [N];
  logic         md_flag [N];
  logic [255:0] md_hash [N];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [255:0] hfun(input logic [31:0] n);
    return {8{n ^ 32'hC3A5_5A3C}};
  endfunction

  for (genvar g = 0; g < N; g++) begin : gen_dut
    hash_job_dispatcher #(
      .NONCE_OFFSET (OFFS[g*32 +: 32]),
      .NONCE_STEP   (STEPS[g*32 +: 32]),
      .TIMEOUT      ((g == 0) ? 10 : 255)
    ) u_dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .job_start       (job_start[g]),
      .job_abort       (job_abort[g]),
      .job_data        (job_data[g]),
      .job_difficulty  (job_difficulty[g]),
      .begin_hash      (begin_hash[g]),
      .quit_hash       (quit_hash[g]),
      .data_to_hash    (data_to_hash[g]),
      .difficulty      (difficulty[g]),
      .hash_done       (hash_done[g]),
      .valid_hash_flag (valid_hash_flag[g]),
      .valid_hash      (valid_hash[g]),
      .job_busy        (job_busy[g]),
      .job_done        (job_done[g]),
      .found           (found[g]),
      .exhausted       (exhausted[g]),
      .timeout_err     (timeout_err[g]),
      .found_nonce     (found_nonce[g]),
      .found_hash      (found_hash[g])
    );
    assign hash_done[g]       = md_done[g] | man_done[g];
    assign valid_hash_flag[g] = man_done[g] ? man_flag[g] : md_flag[g];
    assign valid_hash[g]      = man_done[g] ? man_hash[g] : md_hash[g];
  end

  // Hashing-module model: done MODEL_LAT+1 cycles after begin, valid when nonce == target.
  always @(posedge clk or negedge n_rst) begin
    for (int i = 0; i < N; i++) begin
      if (!n_rst) begin
        mcnt[i]    <= '0;
        mnonce[i]  <= '0;
        md_done[i] <= 1'b0;
        md_flag[i] <= 1'b0;
        md_hash[i] <= '0;
      end else begin
        md_done[i] <= 1'b0;
        if (quit_hash[i]) begin
          mcnt[i] <= '0;
        end else if (begin_hash[i] && !mute[i]) begin
          mcnt[i]   <= MODEL_LAT;
          mnonce[i] <= data_to_hash[i][31:0];
        end else if (mcnt[i] != 0) begin
          mcnt[i] <= mcnt[i] - 3'd1;
          if (mcnt[i] == 3'd1) begin
            md_done[i] <= 1'b1;
            md_flag[i] <= (mnonce[i] == target[i]);
            md_hash[i] <= hfun(mnonce[i]);
          end
        end
      end
    end
  end

  logic [31:0] seen [N][16];
  int bn [N] = '{0, 0, 0};
  int qn [N] = '{0, 0, 0};
  int dn [N] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (begin_hash[i]) begin
        if (bn[i] < 16) seen[i][bn[i]] <= data_to_hash[i][31:0];
        bn[i] <= bn[i] + 1;
      end
      if (quit_hash[i]) qn[i] <= qn[i] + 1;
      if (job_done[i])  dn[i] <= dn[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int i, input logic [479:0] d, input logic [255:0] t);
    @(negedge clk);
    job_start[i]      = 1'b1;
    job_data[i]       = d;
    job_difficulty[i] = t;
    @(negedge clk);
    job_start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int waited = 0;
    while (!job_done[i] && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("job_done_seen", job_done[i], 1'b1);
  endtask

  localparam logic [479:0] D1 = {15{32'h1234_5678}};
  localparam logic [479:0] D2 = {15{32'hDEAD_BEEF}};
  localparam logic [255:0] T1 = {8{32'h0000_FFFF}};
  localparam logic [255:0] T2 = {8{32'h00FF_00FF}};

  initial begin
    int b0, q0, d0, n;
    n_rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      job_start[i] = 1'b0; job_abort[i] = 1'b0; job_data[i] = '0; job_difficulty[i] = '0;
      mute[i] = 1'b0; man_done[i] = 1'b0; man_flag[i] = 1'b0; man_hash[i] = '0;
    end
    target[0] = 32'd0; target[1] = 32'd14; target[2] = 32'd0;

    #12;
    check("rst_begin", begin_hash[0], 1'b0);
    check("rst_quit", quit_hash[0], 1'b0);
    check("rst_data", data_to_hash[0], '0);
    check("rst_diff", difficulty[0], '0);
    check("rst_busy", job_busy[0], 1'b0);
    check("rst_done", job_done[0], 1'b0);
    check("rst_flags", {found[0], exhausted[0], timeout_err[0]}, 3'b000);
    check("rst_fnonce", found_nonce[0], '0);
    check("rst_fhash", found_hash[0], '0);
    @(negedge clk);
    n_rst = 1'b1;

    // Hit on the first attempt.
    start_job(0, D1, T1);
    check("t1_begin", begin_hash[0], 1'b1);
    check("t1_data", data_to_hash[0], {D1, 32'd0});
    check("t1_diff", difficulty[0], T1);
    check("t1_busy", job_busy[0], 1'b1);
    wait_done(0, 50);
    check("t1_found", found[0], 1'b1);
    check("t1_fnonce", found_nonce[0], 32'd0);
    check("t1_fhash", found_hash[0], hfun(32'd0));
    check("t1_exh", exhausted[0], 1'b0);
    @(negedge clk);
    check("t1_idle_busy", job_busy[0], 1'b0);
    check("t1_done_pulse", job_done[0], 1'b0);

    // Watchdog: model never answers.
    mute[0] = 1'b1;
    #1 q0 = qn[0];
    start_job(0, D1, T1);
    n = 0;
    while (!quit_hash[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wd_cycles", n, 11);
    check("wd_done", job_done[0], 1'b1);
    check("wd_tmo", timeout_err[0], 1'b1);
    check("wd_found", found[0], 1'b0);
    @(negedge clk);
    #1;
    check("wd_quit_count", qn[0] - q0, 1);
    check("wd_idle", job_busy[0], 1'b0);

    // Stepping with a start pulse ignored mid-WAIT.
    mute[0] = 1'b0;
    target[0] = 32'd3;
    b0 = bn[0];
    start_job(0, D2, T2);
    check("t2_tmo_cleared", timeout_err[0], 1'b0);
    repeat (2) @(negedge clk);
    job_start[0] = 1'b1;
    @(negedge clk);
    job_start[0] = 1'b0;
    check("t2_nonce_held", data_to_hash[0][31:0], 32'd0);
    check("t2_busy", job_busy[0], 1'b1);
    wait_done(0, 100);
    check("t2_fnonce", found_nonce[0], 32'd3);
    check("t2_fhash", found_hash[0], hfun(32'd3));
    #1;
    check("t2_attempts", bn[0] - b0, 4);
    check("t2_seen1", seen[0][b0+1], 32'd1);
    check("t2_seen3", seen[0][b0+3], 32'd3);

    // Abort colliding with a valid hash_done.
    mute[0] = 1'b1;
    #1 q0 = qn[0];
    start_job(0, D1, T1);
    check("ab_fnonce_cleared", found_nonce[0], 32'd0);
    repeat (3) @(negedge clk);
    man_done[0] = 1'b1; man_flag[0] = 1'b1; man_hash[0] = hfun(32'd0); job_abort[0] = 1'b1;
    @(negedge clk);
    man_done[0] = 1'b0; man_flag[0] = 1'b0; job_abort[0] = 1'b0;
    check("ab_quit", quit_hash[0], 1'b1);
    check("ab_done", job_done[0], 1'b1);
    check("ab_found", found[0], 1'b0);
    check("ab_fnonce", found_nonce[0], 32'd0);
    check("ab_fhash", found_hash[0], '0);
    @(negedge clk);
    #1;
    check("ab_quit_count", qn[0] - q0, 1);
    mute[0] = 1'b0;
    target[0] = 32'd0;
    start_job(0, D2, T2);
    check("ab2_begin", begin_hash[0], 1'b1);
    wait_done(0, 50);
    check("ab2_found", found[0], 1'b1);

    // Offset 2, step 4: hit on nonce 14.
    b0 = bn[1];
    start_job(1, D2, T2);
    check("st_first", data_to_hash[1][31:0], 32'd2);
    wait_done(1, 200);
    check("st_found", found[1], 1'b1);
    check("st_fnonce", found_nonce[1], 32'd14);
    check("st_fhash", found_hash[1], hfun(32'd14));
    #1;
    check("st_attempts", bn[1] - b0, 4);
    check("st_seen1", seen[1][b0+1], 32'd6);
    check("st_seen2", seen[1][b0+2], 32'd10);

    // Exhaustion from 0xFFFF_FFFE.
    d0 = dn[2];
    b0 = bn[2];
    start_job(2, D1, T1);
    check("ex_first", data_to_hash[2][31:0], 32'hFFFF_FFFE);
    wait_done(2, 200);
    check("ex_exh", exhausted[2], 1'b1);
    check("ex_found", found[2], 1'b0);
    @(negedge clk);
    #1;
    check("ex_done_count", dn[2] - d0, 1);
    check("ex_attempts", bn[2] - b0, 2);
    check("ex_seen1", seen[2][b0+1], 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of WAIT.
    target[0] = 32'd7;
    start_job(0, D1, T1);
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("ar_busy", job_busy[0], 1'b0);
    check("ar_begin", begin_hash[0], 1'b0);
    check("ar_quit", quit_hash[0], 1'b0);
    check("ar_data", data_to_hash[0], '0);
    check("ar_diff", difficulty[0], '0);
    @(negedge clk);
    n_rst = 1'b1;
    #1 b0 = bn[0];
    repeat (6) @(negedge clk);
    #1;
    check("ar_no_begin", bn[0] - b0, 0);
    check("ar_idle", job_busy[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
